// File: rtl/iec_bus_conditioner.sv
// rtl/iec_bus_conditioner.sv - IEC line synchroniser/filter/edge detector and phi2 enable generator
// Optional feature macro: IEC_GLITCH_CNT_EN (per-channel rejected-pulse counters).
module iec_bus_conditioner #(
  parameter int   CH          = 3,
  parameter int   SYNC_STAGES = 2,
  parameter int   FILT_LEN    = 1,
  parameter int   DIV         = 32,
  parameter logic RST_LVL     = 1'b1
) (
  input  logic            clk32,
  input  logic            reset,
  input  logic [CH-1:0]   ch_in,
  output logic [CH-1:0]   ch_out,
  output logic [CH-1:0]   ch_rise,
  output logic [CH-1:0]   ch_fall,
  input  logic            run,
  input  logic            fast,
  output logic            fast_act,
  output logic            p2_h_r,
  output logic            p2_h_f,
  input  logic            glitch_clr,
  output logic [8*CH-1:0] glitch_cnt
);

  localparam int             PCW       = $clog2(DIV);
  localparam logic [3:0]     FILT_MAX  = 4'(FILT_LEN);
  localparam logic [4:0]     FILT_CMP  = 5'(FILT_LEN);
  localparam logic [PCW-1:0] LAST_NORM = PCW'(DIV - 1);
  localparam logic [PCW-1:0] LAST_FAST = PCW'(DIV / 2 - 1);
  localparam logic [PCW-1:0] HALF_NORM = PCW'(DIV / 2);
  localparam logic [PCW-1:0] HALF_FAST = PCW'(DIV / 4);

  genvar g;
  for (g = 0; g < CH; g++) begin : g_ch
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;
    logic [3:0]             cnt_q;
    logic                   out_q;
    logic                   rise_q;
    logic                   fall_q;
    logic                   s;
    logic                   accept;

    // s is the metastability-safe copy of the pin; the filter only sees s
    assign s      = sync_q[SYNC_STAGES-1];
    // FILT_LEN consecutive equal comparisons (counter saturated or about to reach it)
    assign accept = (s == prev_q) && (({1'b0, cnt_q} + 5'd1) >= FILT_CMP);

    // Synchroniser chain, idle level on reset so no false edge appears at release
    always_ff @(posedge clk32 or posedge reset) begin
      if (reset) begin
        sync_q <= {SYNC_STAGES{RST_LVL}};
      end else begin
        sync_q <= {sync_q[SYNC_STAGES-2:0], ch_in[g]};
      end
    end

    // Stability filter with registered edge pulses aligned to the ch_out change
    always_ff @(posedge clk32 or posedge reset) begin
      if (reset) begin
        prev_q <= RST_LVL;
        cnt_q  <= 4'd0;
        out_q  <= RST_LVL;
        rise_q <= 1'b0;
        fall_q <= 1'b0;
      end else begin
        prev_q <= s;
        rise_q <= accept & s & ~out_q;
        fall_q <= accept & ~s & out_q;
        if (s != prev_q) begin
          cnt_q <= 4'd0;
        end else if (accept) begin
          cnt_q <= FILT_MAX;
        end else begin
          cnt_q <= cnt_q + 4'd1;
        end
        if (accept) begin
          out_q <= s;
        end
      end
    end

    assign ch_out[g]  = out_q;
    assign ch_rise[g] = rise_q;
    assign ch_fall[g] = fall_q;

`ifdef IEC_GLITCH_CNT_EN
    logic [7:0] gcnt_q;

    // A change of s back to the accepted level means a pulse died in the filter
    always_ff @(posedge clk32 or posedge reset) begin
      if (reset) begin
        gcnt_q <= 8'd0;
      end else if (glitch_clr) begin
        gcnt_q <= 8'd0;
      end else if ((s != prev_q) && (s == out_q) && (gcnt_q != 8'hff)) begin
        gcnt_q <= gcnt_q + 8'd1;
      end
    end

    assign glitch_cnt[8*g +: 8] = gcnt_q;
`else
    assign glitch_cnt[8*g +: 8] = 8'h00;
`endif
  end

`ifndef IEC_GLITCH_CNT_EN
  logic unused_glitch_clr;
  assign unused_glitch_clr = glitch_clr;
`endif

  logic [PCW-1:0] pc_q;
  logic           fast_q;
  logic           p2r_q;
  logic           p2f_q;
  logic           pc_last;
  logic [PCW-1:0] pc_half;

  // Period end and mid point follow the rate latched at the last wrap
  assign pc_last = fast_q ? (pc_q == LAST_FAST) : (pc_q == LAST_NORM);
  assign pc_half = fast_q ? HALF_FAST : HALF_NORM;

  // Phase counter; rate changes only at wrap so a phase is never cut short
  always_ff @(posedge clk32 or posedge reset) begin
    if (reset) begin
      pc_q   <= '0;
      fast_q <= 1'b0;
      p2r_q  <= 1'b0;
      p2f_q  <= 1'b0;
    end else if (run) begin
      p2r_q <= (pc_q == '0);
      p2f_q <= (pc_q == pc_half);
      if (pc_last) begin
        pc_q   <= '0;
        fast_q <= fast;
      end else begin
        pc_q <= pc_q + PCW'(1);
      end
    end else begin
      p2r_q <= 1'b0;
      p2f_q <= 1'b0;
    end
  end

  assign fast_act = fast_q;
  assign p2_h_r   = p2r_q;
  assign p2_h_f   = p2f_q;

endmodule

// File: tb/tb_iec_bus_conditioner.sv
// tb/tb_iec_bus_conditioner.sv - self-checking bench for iec_bus_conditioner (FILT_LEN 1 and 3 instances)
`timescale 1ns/1ps
module tb_iec_bus_conditioner;

  localparam int   CH      = 3;
  localparam int   SYNC    = 2;
  localparam int   DIV     = 32;
  localparam logic RST_LVL = 1'b1;
`ifdef IEC_GLITCH_CNT_EN
  localparam bit GEN = 1'b1;
`else
  localparam bit GEN = 1'b0;
`endif

  logic clk32 = 1'b0;
  always #5 clk32 = ~clk32;

  logic            reset;
  logic [CH-1:0]   ch_in;
  logic            run, fast, glitch_clr;
  logic [CH-1:0]   a_out, a_rise, a_fall, b_out, b_rise, b_fall;
  logic            a_fast, a_r, a_f, b_fast, b_r, b_f;
  logic [8*CH-1:0] a_g, b_g;

  iec_bus_conditioner dut_a (
    .clk32(clk32), .reset(reset), .ch_in(ch_in), .ch_out(a_out), .ch_rise(a_rise),
    .ch_fall(a_fall), .run(run), .fast(fast), .fast_act(a_fast), .p2_h_r(a_r),
    .p2_h_f(a_f), .glitch_clr(glitch_clr), .glitch_cnt(a_g)
  );

  iec_bus_conditioner #(.FILT_LEN(3)) dut_b (
    .clk32(clk32), .reset(reset), .ch_in(ch_in), .ch_out(b_out), .ch_rise(b_rise),
    .ch_fall(b_fall), .run(run), .fast(fast), .fast_act(b_fast), .p2_h_r(b_r),
    .p2_h_f(b_f), .glitch_clr(glitch_clr), .glitch_cnt(b_g)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: input history window, rule-based filter, period arithmetic
  logic [CH-1:0] h [0:15];
  logic [CH-1:0] m_out [0:1];
  logic [CH-1:0] m_rise [0:1];
  logic [CH-1:0] m_fall [0:1];
  int            m_g [0:1][0:CH-1];
  int            m_pos, m_per;
  logic          m_fast, m_r, m_f;
  int            fl;
  bit            st, ov, nv, gl;

  always @(posedge clk32 or posedge reset) begin
    if (reset) begin
      for (int d = 0; d < 16; d++) h[d] = {CH{RST_LVL}};
      for (int k = 0; k < 2; k++) begin
        m_out[k] = {CH{RST_LVL}};
        m_rise[k] = '0;
        m_fall[k] = '0;
        for (int c = 0; c < CH; c++) m_g[k][c] = 0;
      end
      m_pos = 0; m_per = DIV; m_fast = 1'b0; m_r = 1'b0; m_f = 1'b0;
    end else begin
      for (int d = 15; d > 0; d--) h[d] = h[d-1];
      h[0] = ch_in;
      for (int k = 0; k < 2; k++) begin
        fl = (k == 0) ? 1 : 3;
        for (int c = 0; c < CH; c++) begin
          // accepted once FILT_LEN+1 consecutive synchronised samples agree
          st = 1'b1;
          for (int j = SYNC; j <= SYNC + fl; j++) if (h[j][c] != h[SYNC][c]) st = 1'b0;
          ov = m_out[k][c];
          gl = (h[SYNC][c] != h[SYNC+1][c]) && (h[SYNC][c] == ov);
          if (glitch_clr) m_g[k][c] = 0;
          else if (GEN && gl && m_g[k][c] < 255) m_g[k][c] = m_g[k][c] + 1;
          nv = st ? h[SYNC][c] : ov;
          m_out[k][c] = nv;
          m_rise[k][c] = nv & ~ov;
          m_fall[k][c] = ~nv & ov;
        end
      end
      if (run) begin
        m_r = (m_pos == 0);
        m_f = (m_pos == m_per / 2);
        m_pos = m_pos + 1;
        if (m_pos == m_per) begin
          m_pos = 0;
          m_fast = fast;
          m_per = fast ? DIV / 2 : DIV;
        end
      end else begin
        m_r = 1'b0;
        m_f = 1'b0;
      end
    end
  end

  function automatic logic [8*CH-1:0] exp_g(input int k);
    logic [8*CH-1:0] v;
    v = '0;
    for (int c = 0; c < CH; c++) v[8*c +: 8] = 8'(m_g[k][c]);
    return v;
  endfunction

  task automatic tick();
    @(posedge clk32);
    #1;
  endtask

  // Advance until p2_h_r; n = edges taken, fpos = edge of p2_h_f, fones = edges with fast_act
  task automatic wait_r(input int lim, output int n, output int fpos, output int fones);
    n = 0; fpos = -1; fones = 0;
    do begin
      tick();
      n++;
      if (a_f) fpos = n;
      if (a_fast) fones++;
    end while (!a_r && n < lim);
  endtask

  task automatic test_reset();
    reset = 1'b0; ch_in = '1; run = 1'b1; fast = 1'b0; glitch_clr = 1'b0;
    #2 reset = 1'b1;
    #10;
    checks++; if ({a_out, b_out} !== {2*CH{RST_LVL}}) begin errors++; $display("FAIL reset_out got %b exp %b", {a_out, b_out}, {2*CH{RST_LVL}}); end
    checks++; if ({a_rise, a_fall, b_rise, b_fall} !== '0) begin errors++; $display("FAIL reset_edges got %b exp 0", {a_rise, a_fall, b_rise, b_fall}); end
    checks++; if ({a_r, a_f, a_fast, b_r, b_f, b_fast} !== 6'b0) begin errors++; $display("FAIL reset_phase got %b exp 000000", {a_r, a_f, a_fast, b_r, b_f, b_fast}); end
    checks++; if ({a_g, b_g} !== '0) begin errors++; $display("FAIL reset_glitch got %h exp 0", {a_g, b_g}); end
    @(posedge clk32);
    #1 reset = 1'b0;
    tick();
    checks++; if ({a_r, a_f} !== 2'b10) begin errors++; $display("FAIL first_p2r got %b exp 10", {a_r, a_f}); end
  endtask

  task automatic test_idle();
    int rq[$];
    int fq[$];
    rq.push_back(0);
    for (int i = 1; i <= 130; i++) begin
      tick();
      if (a_r) rq.push_back(i);
      if (a_f) fq.push_back(i);
      checks++; if ({a_r, a_f, a_fast} !== {m_r, m_f, m_fast}) begin errors++; $display("FAIL idle_phase cyc %0d got %b exp %b", i, {a_r, a_f, a_fast}, {m_r, m_f, m_fast}); end
      checks++; if ({a_out, a_rise, a_fall} !== {3'b111, 6'b0}) begin errors++; $display("FAIL idle_lines cyc %0d got %b exp 111000000", i, {a_out, a_rise, a_fall}); end
    end
    checks++; if (rq.size() != 5 || fq.size() != 4) begin errors++; $display("FAIL idle_counts got r=%0d f=%0d exp r=5 f=4", rq.size(), fq.size()); end
    for (int i = 1; i < rq.size(); i++) begin
      checks++; if (rq[i] - rq[i-1] != DIV) begin errors++; $display("FAIL idle_r_spacing got %0d exp %0d", rq[i] - rq[i-1], DIV); end
    end
    for (int i = 0; i < fq.size() && i < rq.size(); i++) begin
      checks++; if (fq[i] - rq[i] != DIV / 2) begin errors++; $display("FAIL idle_f_offset got %0d exp %0d", fq[i] - rq[i], DIV / 2); end
    end
  endtask

  task automatic test_step();
    int na, nb, fa, fb, lowa, lowb;
    na = 0; nb = 0; fa = 0; fb = 0;
    ch_in[0] = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (a_out[0] === 1'b0 && na == 0) na = i;
      if (b_out[0] === 1'b0 && nb == 0) nb = i;
      if (a_fall[0]) fa++;
      if (b_fall[0]) fb++;
      if (i == na) begin
        checks++; if ({a_fall[0], a_rise[0]} !== 2'b10) begin errors++; $display("FAIL step_fall_pulse got %b exp 10", {a_fall[0], a_rise[0]}); end
      end
    end
    checks++; if (na != SYNC + 2) begin errors++; $display("FAIL step_latency_a got %0d exp %0d", na, SYNC + 2); end
    checks++; if (nb != SYNC + 4) begin errors++; $display("FAIL step_latency_b got %0d exp %0d", nb, SYNC + 4); end
    checks++; if (fa != 1 || fb != 1) begin errors++; $display("FAIL step_fall_count got a=%0d b=%0d exp 1", fa, fb); end
    ch_in[0] = 1'b1;
    repeat (12) tick();
    checks++; if ({a_out[0], b_out[0]} !== 2'b11) begin errors++; $display("FAIL step_return got %b exp 11", {a_out[0], b_out[0]}); end
    ch_in[0] = 1'b0;
    tick();
    ch_in[0] = 1'b1;
    lowa = 0; lowb = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (a_out[0] !== 1'b1 || a_fall[0]) lowa++;
      if (b_out[0] !== 1'b1 || b_fall[0]) lowb++;
    end
    checks++; if (lowa != 0 || lowb != 0) begin errors++; $display("FAIL pulse1_reject got a=%0d b=%0d exp 0", lowa, lowb); end
    checks++; if (a_g[7:0] !== 8'(GEN) || b_g[7:0] !== 8'(GEN)) begin errors++; $display("FAIL pulse1_glitch got a=%0d b=%0d exp %0d", a_g[7:0], b_g[7:0], GEN); end
    checks++; if ({a_g, b_g} !== {exp_g(0), exp_g(1)}) begin errors++; $display("FAIL pulse1_model got %h exp %h", {a_g, b_g}, {exp_g(0), exp_g(1)}); end
  endtask

  task automatic test_filt3();
    int lowb, fa, fb, rb;
    ch_in[1] = 1'b0;
    repeat (3) tick();
    ch_in[1] = 1'b1;
    lowb = 0; fa = 0;
    for (int i = 0; i < 14; i++) begin
      tick();
      if (b_out[1] !== 1'b1) lowb++;
      if (a_fall[1]) fa++;
    end
    checks++; if (lowb != 0) begin errors++; $display("FAIL f3_pulse3_reject got %0d low cycles exp 0", lowb); end
    checks++; if (fa != 1) begin errors++; $display("FAIL f1_pulse3_accept got %0d falls exp 1", fa); end
    checks++; if (b_g[15:8] !== 8'(GEN) || a_g[15:8] !== 8'd0) begin errors++; $display("FAIL pulse3_glitch got a=%0d b=%0d exp a=0 b=%0d", a_g[15:8], b_g[15:8], GEN); end
    ch_in[1] = 1'b0;
    repeat (4) tick();
    ch_in[1] = 1'b1;
    lowb = 0; fb = 0; rb = 0;
    for (int i = 0; i < 16; i++) begin
      tick();
      if (b_out[1] === 1'b0) lowb++;
      if (b_fall[1]) fb++;
      if (b_rise[1]) rb++;
    end
    checks++; if (lowb == 0 || fb != 1 || rb != 1) begin errors++; $display("FAIL f3_pulse4_accept got low=%0d fall=%0d rise=%0d exp low>0 fall=1 rise=1", lowb, fb, rb); end
    checks++; if (b_g[15:8] !== 8'(GEN)) begin errors++; $display("FAIL pulse4_glitch got %0d exp %0d", b_g[15:8], GEN); end
    for (int i = 0; i < 600; i++) begin
      ch_in[2] = ~ch_in[2];
      tick();
    end
    repeat (8) tick();
    checks++; if (a_g[23:16] !== (GEN ? 8'd255 : 8'd0) || b_g[23:16] !== (GEN ? 8'd255 : 8'd0)) begin errors++; $display("FAIL glitch_sat got a=%0d b=%0d exp %0d", a_g[23:16], b_g[23:16], GEN ? 255 : 0); end
    checks++; if ({a_g, b_g} !== {exp_g(0), exp_g(1)}) begin errors++; $display("FAIL glitch_sat_model got %h exp %h", {a_g, b_g}, {exp_g(0), exp_g(1)}); end
    checks++; if ({a_out[2], b_out[2]} !== 2'b11) begin errors++; $display("FAIL toggle_reject got %b exp 11", {a_out[2], b_out[2]}); end
    glitch_clr = 1'b1;
    tick();
    glitch_clr = 1'b0;
    checks++; if (a_g[23:16] !== 8'd0 || b_g[23:16] !== 8'd0) begin errors++; $display("FAIL glitch_clr got a=%0d b=%0d exp 0", a_g[23:16], b_g[23:16]); end
    ch_in[2] = 1'b0;
    tick();
    ch_in[2] = 1'b1;
    tick();
    tick();
    glitch_clr = 1'b1;
    tick();
    glitch_clr = 1'b0;
    checks++; if ({a_g, b_g} !== {exp_g(0), exp_g(1)}) begin errors++; $display("FAIL clr_vs_inc_model got %h exp %h", {a_g, b_g}, {exp_g(0), exp_g(1)}); end
    tick();
    checks++; if (a_g[23:16] !== 8'd0 || b_g[23:16] !== 8'd0) begin errors++; $display("FAIL clr_wins got a=%0d b=%0d exp 0", a_g[23:16], b_g[23:16]); end
  endtask

  task automatic test_fast();
    int n, fp, fo;
    wait_r(40, n, fp, fo);
    repeat (4) tick();
    fast = 1'b1;
    wait_r(40, n, fp, fo);
    checks++; if (n + 4 != DIV || fp + 4 != DIV / 2 || fo != 2) begin errors++; $display("FAIL fast_req_period got n=%0d f=%0d fa=%0d exp n=%0d f=%0d fa=2", n + 4, fp + 4, fo, DIV, DIV / 2); end
    wait_r(40, n, fp, fo);
    checks++; if (n != DIV / 2 || fp != DIV / 4 || fo != n) begin errors++; $display("FAIL fast_period got n=%0d f=%0d fa=%0d exp n=%0d f=%0d fa=%0d", n, fp, fo, DIV / 2, DIV / 4, DIV / 2); end
    fast = 1'b0;
    wait_r(40, n, fp, fo);
    checks++; if (n != DIV / 2 || fp != DIV / 4 || fo != DIV / 2 - 2) begin errors++; $display("FAIL slow_req_period got n=%0d f=%0d fa=%0d exp n=%0d f=%0d fa=%0d", n, fp, fo, DIV / 2, DIV / 4, DIV / 2 - 2); end
    wait_r(40, n, fp, fo);
    checks++; if (n != DIV || fp != DIV / 2 || fo != 0) begin errors++; $display("FAIL slow_period got n=%0d f=%0d fa=%0d exp n=%0d f=%0d fa=0", n, fp, fo, DIV, DIV / 2); end
  endtask

  task automatic test_run_hold();
    int n, fp, fo, pulses;
    repeat (9) tick();
    run = 1'b0;
    fast = 1'b1;
    pulses = 0;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (a_r || a_f || a_fast) pulses++;
    end
    checks++; if (pulses != 0) begin errors++; $display("FAIL hold_quiet got %0d active cycles exp 0", pulses); end
    fast = 1'b0;
    run = 1'b1;
    wait_r(40, n, fp, fo);
    checks++; if (9 + n != DIV || n - fp != DIV / 2) begin errors++; $display("FAIL hold_resume got span=%0d f_to_r=%0d exp span=%0d f_to_r=%0d", 9 + n, n - fp, DIV, DIV / 2); end
  endtask

  task automatic test_reset_mid();
    int n, fp, fo;
    fast = 1'b1;
    wait_r(40, n, fp, fo);
    wait_r(40, n, fp, fo);
    checks++; if (a_fast !== 1'b1) begin errors++; $display("FAIL pre_reset_fast got %b exp 1", a_fast); end
    ch_in = '0;
    repeat (10) tick();
    checks++; if ({a_out, b_out} !== '0) begin errors++; $display("FAIL pre_reset_low got %b exp 0", {a_out, b_out}); end
    repeat (3) tick();
    #2 reset = 1'b1;
    #1;
    checks++; if ({a_out, b_out} !== {2*CH{RST_LVL}}) begin errors++; $display("FAIL midreset_out got %b exp %b", {a_out, b_out}, {2*CH{RST_LVL}}); end
    checks++; if ({a_r, a_f, a_fast, a_rise, a_fall, b_rise, b_fall} !== '0) begin errors++; $display("FAIL midreset_pulses got %b exp 0", {a_r, a_f, a_fast, a_rise, a_fall, b_rise, b_fall}); end
    ch_in = '1;
    fast = 1'b0;
    @(posedge clk32);
    #1 reset = 1'b0;
    tick();
    checks++; if ({a_r, a_f, a_out} !== {2'b10, 3'b111}) begin errors++; $display("FAIL midreset_first_p2r got %b exp 10111", {a_r, a_f, a_out}); end
  endtask

  task automatic test_random();
    int rate;
    for (int i = 0; i < 3000; i++) begin
      rate = ((i / 500) % 2 == 1) ? 3 : 9;
      for (int c = 0; c < CH; c++) if ($urandom_range(rate) == 0) ch_in[c] = ~ch_in[c];
      if ($urandom_range(63) == 0) run = ~run;
      if ($urandom_range(99) == 0) fast = ~fast;
      glitch_clr = ($urandom_range(199) == 0);
      tick();
      checks++; if ({a_out, a_rise, a_fall} !== {m_out[0], m_rise[0], m_fall[0]}) begin errors++; $display("FAIL rnd_filt_a cyc %0d got %b exp %b", i, {a_out, a_rise, a_fall}, {m_out[0], m_rise[0], m_fall[0]}); end
      checks++; if ({b_out, b_rise, b_fall} !== {m_out[1], m_rise[1], m_fall[1]}) begin errors++; $display("FAIL rnd_filt_b cyc %0d got %b exp %b", i, {b_out, b_rise, b_fall}, {m_out[1], m_rise[1], m_fall[1]}); end
      checks++; if ({a_r, a_f, a_fast, b_r, b_f, b_fast} !== {m_r, m_f, m_fast, m_r, m_f, m_fast}) begin errors++; $display("FAIL rnd_phase cyc %0d got %b exp %b", i, {a_r, a_f, a_fast, b_r, b_f, b_fast}, {m_r, m_f, m_fast, m_r, m_f, m_fast}); end
      checks++; if ({a_g, b_g} !== {exp_g(0), exp_g(1)}) begin errors++; $display("FAIL rnd_glitch cyc %0d got %h exp %h", i, {a_g, b_g}, {exp_g(0), exp_g(1)}); end
    end
    glitch_clr = 1'b0;
  endtask

  initial begin
    test_reset();
    test_idle();
    test_step();
    test_filt3();
    test_fast();
    test_run_hold();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog timeout after %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
